// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite master bridge: FSM state codes, response codes,
// default widths and the watchdog counter sizing helper.
package axi_lite_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_AR   = 3'd1;
   localparam logic [2:0] ST_R    = 3'd2;
   localparam logic [2:0] ST_AW_W = 3'd3;
   localparam logic [2:0] ST_B    = 3'd4;
   localparam logic [2:0] ST_RESP = 3'd5;

   localparam logic RESP_OKAY = 1'b0;
   localparam logic RESP_ERR  = 1'b1;

   // Counter only has to reach TIMEOUT-1; keep at least one bit so a disabled watchdog still elaborates.
   function automatic int timer_w(input int timeout);
      return (timeout <= 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI-lite initiator: converts a CPU valid/ready request into an AR/R or
// AW/W/B exchange and returns a registered response, with an optional hang watchdog.
module axi_lite_master_bridge
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic                rresp,
   input  logic                rvalid,
   output logic                rready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic                bresp,
   input  logic                bvalid,
   output logic                bready
);

   localparam int STRB_W = DATA_W / 8;
   localparam int TMR_W  = timer_w(TIMEOUT);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              aw_hs, w_hs, wd_expired;

   // All AXI/CPU handshake outputs decode from registered state only, so no ready->valid path exists.
   assign req_ready  = (state_q == ST_IDLE);
   assign arvalid    = (state_q == ST_AR);
   assign rready     = (state_q == ST_R);
   assign awvalid    = (state_q == ST_AW_W) && !aw_done_q;
   assign wvalid     = (state_q == ST_AW_W) && !w_done_q;
   assign bready     = (state_q == ST_B);
   assign resp_valid = (state_q == ST_RESP);
   assign araddr     = addr_q;
   assign awaddr     = addr_q;
   assign wdata      = wdata_q;
   assign wstrb      = wstrb_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   assign aw_hs      = awvalid && awready;
   assign w_hs       = wvalid && wready;
   assign wd_expired = (TIMEOUT > 0) && (timer_q == TMR_W'(TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      timer_d   = timer_q;

      // Timer saturates at TIMEOUT-1 so a phase completing exactly at expiry cannot wrap it.
      if ((state_q inside {ST_AR, ST_R, ST_AW_W, ST_B}) && !wd_expired) begin
         timer_d = timer_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               wstrb_d   = req_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               timer_d   = '0;
               state_d   = req_wen ? ST_AW_W : ST_AR;
            end
         end
         ST_AR: begin
            if (arready) begin
               state_d = ST_R;
            end else if (wd_expired) begin
               state_d = ST_RESP;
               err_d   = RESP_ERR;
               rdata_d = '0;
            end
         end
         ST_R: begin
            if (rvalid) begin
               rdata_d = rdata;
               err_d   = rresp;
               state_d = ST_RESP;
            end else if (wd_expired) begin
               state_d = ST_RESP;
               err_d   = RESP_ERR;
               rdata_d = '0;
            end
         end
         ST_AW_W: begin
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q || w_hs;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_B;
            end else if (wd_expired) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_RESP;
               err_d     = RESP_ERR;
               rdata_d   = '0;
            end
         end
         ST_B: begin
            if (bvalid) begin
               err_d   = bresp;
               rdata_d = '0;
               state_d = ST_RESP;
            end else if (wd_expired) begin
               state_d = ST_RESP;
               err_d   = RESP_ERR;
               rdata_d = '0;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         timer_q   <= '0;
         rdata_q   <= '0;
         err_q     <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         timer_q   <= timer_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: table vectors, hand-written timing sequences and randomized
// transactions against a delay-programmable slave and a byte-level reference memory.
module tb_axi_lite_master_bridge;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0, req_ready, req_wen = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [SW-1:0] req_wstrb = '0;
   logic          resp_valid, resp_ready = 1'b0, resp_err;
   logic [DW-1:0] resp_rdata;
   logic [AW-1:0] araddr, awaddr;
   logic          arvalid, arready = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic          rresp = 1'b0, rvalid = 1'b0, rready;
   logic          awvalid, awready = 1'b0;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          wvalid, wready = 1'b0;
   logic          bresp = 1'b0, bvalid = 1'b0, bready;

   always #5 clk = ~clk;

   axi_lite_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // ---------------- slave with programmable per-channel delays ----------------
   int  ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   bit  r_never = 1'b0;
   logic [31:0] smem [logic [31:0]];

   function automatic logic is_err_addr(input logic [31:0] a);
      return a[31:28] == 4'hF;
   endfunction

   logic        s_arhs = 1'b0, s_rhs = 1'b0, s_awhs = 1'b0, s_whs = 1'b0, s_bhs = 1'b0;
   logic [31:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0;
   logic [3:0]  s_wstrb = '0;

   initial begin
      forever begin
         @(posedge clk);
         s_arhs   = arvalid && arready;
         s_rhs    = rvalid && rready;
         s_awhs   = awvalid && awready;
         s_whs    = wvalid && wready;
         s_bhs    = bvalid && bready;
         s_araddr = araddr;
         s_awaddr = awaddr;
         s_wdata  = wdata;
         s_wstrb  = wstrb;
      end
   end

   initial begin
      int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
      bit r_busy = 0, b_busy = 0, got_aw = 0, got_w = 0;
      logic [31:0] r_addr = '0, wa = '0, wd = '0, old;
      logic [3:0]  ws = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            r_busy = 0; b_busy = 0; got_aw = 0; got_w = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
         end else begin
            if (s_rhs) begin rvalid = 0; r_busy = 0; end
            if (s_arhs) begin r_busy = 1; r_cnt = 0; r_addr = s_araddr; end
            if (r_busy && !rvalid) begin
               if (!r_never && r_cnt >= r_dly) begin
                  rvalid = 1;
                  rresp  = is_err_addr(r_addr);
                  rdata  = rresp ? 32'hBAD0_BAD0 : (smem.exists(r_addr) ? smem[r_addr] : 32'h0);
               end
               r_cnt++;
            end
            if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end

            if (s_bhs) begin bvalid = 0; b_busy = 0; end
            if (s_awhs) begin got_aw = 1; wa = s_awaddr; end
            if (s_whs) begin got_w = 1; wd = s_wdata; ws = s_wstrb; end
            if (got_aw && got_w) begin
               got_aw = 0; got_w = 0;
               bresp  = is_err_addr(wa);
               if (!bresp) begin
                  old = smem.exists(wa) ? smem[wa] : 32'h0;
                  for (int i = 0; i < 4; i++) if (ws[i]) old[8*i +: 8] = wd[8*i +: 8];
                  smem[wa] = old;
               end
               b_busy = 1; b_cnt = 0;
            end
            if (b_busy && !bvalid) begin
               if (b_cnt >= b_dly) bvalid = 1;
               b_cnt++;
            end
            if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
         end
      end
   end

   // ---------------- reference memory (byte granular) ----------------
   logic [7:0] ref_b [logic [31:0]];

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      logic [31:0] v = '0;
      for (int i = 0; i < 4; i++) if (ref_b.exists(a + 32'(i))) v[8*i +: 8] = ref_b[a + 32'(i)];
      return v;
   endfunction

   function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i]) ref_b[a + 32'(i)] = d[8*i +: 8];
   endfunction

   // ---------------- CPU-side helpers ----------------
   task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
      ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
   endtask

   task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
      lat = -1;
      for (int j = 0; j < 40; j++) begin
         if (resp_valid) begin lat = j; break; end
         @(negedge clk);
      end
      checks++;
      if (lat < 0) begin
         failures++;
         $display("FAIL resp_wait actual=no resp_valid required=resp_valid within 40 cycles");
      end
      rd = resp_rdata;
      er = resp_err;
   endtask

   task automatic ack_resp(input int hold);
      logic [31:0] d0 = resp_rdata;
      logic        e0 = resp_err;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk1("resp_hold_valid", resp_valid, 1'b1);
         chk32("resp_hold_rdata", resp_rdata, d0);
         chk1("resp_hold_err", resp_err, e0);
         chk1("req_ready_busy", req_ready, 1'b0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic issue(input logic wen, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      chk1("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d; req_wstrb = s;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic do_txn(input logic wen, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold, output logic [31:0] rd, output logic er, output int lat);
      issue(wen, a, d, s);
      wait_resp(rd, er, lat);
      ack_resp(hold);
   endtask

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [31:0] rd, a, d;
      logic        er, wen, e_err;
      logic [3:0]  s;
      int          lat, hold, e_lat;

      vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
      vecs[1] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
      vecs[2] = '{1'b1, 32'h8000_0020, 32'h1234_5678, 4'h3, 32'h0000_0000, 1'b0};
      vecs[3] = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h0000_5678, 1'b0};
      vecs[4] = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'hC, 32'h0000_0000, 1'b0};
      vecs[5] = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'hAABB_5678, 1'b0};
      vecs[6] = '{1'b0, 32'hF000_0000, 32'h0,         4'h0, 32'hBAD0_BAD0, 1'b1};
      vecs[7] = '{1'b1, 32'hF000_0004, 32'h5555_AAAA, 4'hF, 32'h0000_0000, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_arvalid", arvalid, 1'b0);
      chk1("rst_rready", rready, 1'b0);
      chk1("rst_awvalid", awvalid, 1'b0);
      chk1("rst_wvalid", wvalid, 1'b0);
      chk1("rst_bready", bready, 1'b0);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk32("rst_resp_rdata", resp_rdata, 32'h0);
      chk1("rst_resp_err", resp_err, 1'b0);
      @(posedge clk); #2 rst = 1'b1;

      // Table vectors against a zero-wait slave
      set_dly(0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         do_txn(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, rd, er, lat);
         chk32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk1($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
         chk32($sformatf("vec%0d_latency", i), lat, 32'd2);
      end

      // Split write handshake: AW immediately, W three cycles late
      set_dly(0, 0, 0, 3, 0);
      issue(1'b1, 32'h8000_0030, 32'h0BAD_F00D, 4'hF);
      chk1("split_awvalid_n1", awvalid, 1'b1);
      chk1("split_wvalid_n1", wvalid, 1'b1);
      chk32("split_awaddr", awaddr, 32'h8000_0030);
      chk32("split_wdata", wdata, 32'h0BAD_F00D);
      chk32("split_wstrb", 32'(wstrb), 32'hF);
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         chk1($sformatf("split_awvalid_n%0d", j + 1), awvalid, 1'b0);
         chk1($sformatf("split_wvalid_n%0d", j + 1), wvalid, 1'b1);
         chk1($sformatf("split_bready_n%0d", j + 1), bready, 1'b0);
      end
      @(negedge clk);
      chk1("split_wvalid_n5", wvalid, 1'b0);
      chk1("split_bready_n5", bready, 1'b1);
      wait_resp(rd, er, lat);
      chk1("split_err", er, 1'b0);
      chk32("split_rdata", rd, 32'h0);
      ack_resp(0);

      // Read backpressure on AR and on the response
      set_dly(3, 0, 0, 0, 0);
      issue(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      for (int j = 0; j < 4; j++) begin
         if (j > 0) @(negedge clk);
         chk1($sformatf("bp_arvalid_%0d", j), arvalid, 1'b1);
         chk32($sformatf("bp_araddr_%0d", j), araddr, 32'h8000_0010);
         chk1($sformatf("bp_req_ready_%0d", j), req_ready, 1'b0);
      end
      @(negedge clk);
      chk1("bp_rready", rready, 1'b1);
      wait_resp(rd, er, lat);
      chk32("bp_rdata", rd, 32'hDEAD_BEEF);
      ack_resp(2);

      // A request presented while the response is consumed is accepted only in IDLE
      set_dly(0, 0, 0, 0, 0);
      issue(1'b0, 32'h8000_0020, 32'h0, 4'h0);
      wait_resp(rd, er, lat);
      resp_ready = 1'b1; req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
      @(negedge clk);
      resp_ready = 1'b0;
      chk1("overlap_no_accept_arvalid", arvalid, 1'b0);
      chk1("overlap_idle_req_ready", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      chk1("overlap_accept_arvalid", arvalid, 1'b1);
      wait_resp(rd, er, lat);
      chk32("overlap_rdata", rd, 32'hDEAD_BEEF);
      ack_resp(0);

      // Watchdog: slave never returns read data
      r_never = 1'b1;
      issue(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         if (j < 8) chk1($sformatf("wd_resp_valid_%0d", j), resp_valid, 1'b0);
         if (j == 7) chk1("wd_rready_last", rready, 1'b1);
      end
      chk1("wd_rready_dropped", rready, 1'b0);
      chk1("wd_resp_valid", resp_valid, 1'b1);
      chk1("wd_resp_err", resp_err, 1'b1);
      chk32("wd_resp_rdata", resp_rdata, 32'h0);
      ack_resp(0);
      r_never = 1'b0;
      do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
      chk32("wd_next_rdata", rd, 32'hDEAD_BEEF);
      chk1("wd_next_err", er, 1'b0);

      // Asynchronous reset in the middle of a write
      set_dly(0, 0, 5, 5, 0);
      issue(1'b1, 32'h8000_0040, 32'h7777_7777, 4'hF);
      @(negedge clk);
      chk1("arst_awvalid_before", awvalid, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk1("arst_awvalid", awvalid, 1'b0);
      chk1("arst_wvalid", wvalid, 1'b0);
      chk1("arst_resp_valid", resp_valid, 1'b0);
      chk1("arst_bready", bready, 1'b0);
      @(posedge clk); #2 rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk1("arst_post_req_ready", req_ready, 1'b1);
         chk1("arst_post_bready", bready, 1'b0);
      end
      set_dly(0, 0, 0, 0, 0);
      do_txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lat);
      chk32("arst_next_rdata", rd, 32'hAABB_5678);

      // Randomized traffic in a separate region, checked against the byte-level model
      for (int n = 0; n < 40; n++) begin
         wen  = 1'($urandom_range(0, 1));
         a    = (($urandom_range(0, 9) == 0) ? 32'hF000_1000 : 32'h8000_1000) + 32'($urandom_range(0, 7) * 4);
         d    = $urandom;
         s    = 4'($urandom_range(0, 15));
         hold = $urandom_range(0, 2);
         set_dly($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2));
         e_err = (a[31:28] == 4'hF);
         e_lat = wen ? ((aw_dly > w_dly ? aw_dly : w_dly) + b_dly + 2) : (ar_dly + r_dly + 2);
         do_txn(wen, a, d, s, hold, rd, er, lat);
         if (wen) begin
            chk32($sformatf("rnd%0d_wr_rdata", n), rd, 32'h0);
            if (!e_err) ref_write(a, d, s);
         end else begin
            chk32($sformatf("rnd%0d_rd_rdata", n), rd, e_err ? 32'hBAD0_BAD0 : ref_read(a));
         end
         chk1($sformatf("rnd%0d_err", n), er, e_err);
         chk32($sformatf("rnd%0d_latency", n), lat, e_lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=simulation still running required=finished within 200000");
      $fatal(1);
   end

endmodule
